// File: rtl/latency_arbiter.sv
// latency_arbiter: round-robin arbiter and fixed-latency sequencer for a
// shared resource. It grants one requester, counts LATENCY ce-qualified
// clocks, then holds a level ack plus the captured 4-bit transaction id until
// the owner drops its request.
//
// Optional feature: define LATENCY_ARB_B2B_EN to re-arbitrate on the release
// edge, so a new owner is granted with no dead cycle in between.
//
// Ports:
//   clk_i   clock (rising edge)
//   rst_ni  asynchronous active-low reset
//   ce_i    clock enable; all state holds while low
//   req_i   [NREQ]    per-requester request (may drop at any time = abort)
//   id_i    [4*NREQ]  per-requester transaction id, requester n at [4n+3:4n]
//   gnt_o   [NREQ]    one-hot grant (resource mux select)
//   ack_o   [NREQ]    one-hot ack to the owner
//   id_o    [4]       captured id while an ack is high, else 0
//   busy_o            high while waiting on latency or acking
module latency_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned LATENCY = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ce_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [4*NREQ-1:0] id_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   ack_o,
  output logic [3:0]        id_o,
  output logic              busy_o
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = 4;
  localparam int unsigned IDW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    rr_q, rr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDW-1:0]   cap_q, cap_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             busy_q, busy_d;

  logic [NREQ-1:0]  req_m;
  logic             arb_found;
  logic [IW-1:0]    arb_win;
  logic [IDW-1:0]   arb_id;
  logic [IW-1:0]    arb_rr_next;
  int unsigned      idx;

  // Requests eligible for arbitration; with back-to-back enabled the
  // releasing owner is masked out on its own release edge.
  always_comb begin
    req_m = req_i;
`ifdef LATENCY_ARB_B2B_EN
    if (state_q == S_ACK) begin
      req_m[owner_q] = 1'b0;
    end
`endif
  end

  // Round-robin search upward from rr_q, wrapping modulo NREQ.
  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!arb_found && req_m[IW'(idx)]) begin
        arb_found = 1'b1;
        arb_win   = IW'(idx);
      end
    end
  end

  // Id mux and next pointer for the arbitration winner.
  always_comb begin
    arb_id = '0;
    for (int unsigned n = 0; n < NREQ; n++) begin
      if (arb_win == IW'(n)) arb_id = id_i[4*n +: 4];
    end
    arb_rr_next = (32'(arb_win) == NREQ - 1) ? '0 : IW'(32'(arb_win) + 1);
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    gnt_d   = gnt_q;
    ack_d   = ack_q;
    id_d    = id_q;
    busy_d  = busy_q;

    if (ce_i) begin
      unique case (state_q)
        S_IDLE: begin
          if (arb_found) begin
            state_d = S_WAIT;
            owner_d = arb_win;
            rr_d    = arb_rr_next;
            cnt_d   = CW'(LATENCY - 1);
            cap_d   = arb_id;
            gnt_d   = NREQ'(1) << arb_win;
          end
        end
        S_WAIT: begin
          if (!req_i[owner_q]) begin
            // Abort: no ack, pointer stays advanced past the aborted owner.
            state_d = S_IDLE;
            gnt_d   = '0;
          end else if (cnt_q == '0) begin
            state_d = S_ACK;
            ack_d   = gnt_q;
            id_d    = cap_q;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_ACK: begin
          if (!req_i[owner_q]) begin
            state_d = S_IDLE;
            gnt_d   = '0;
            ack_d   = '0;
            id_d    = '0;
`ifdef LATENCY_ARB_B2B_EN
            if (arb_found) begin
              state_d = S_WAIT;
              owner_d = arb_win;
              rr_d    = arb_rr_next;
              cnt_d   = CW'(LATENCY - 1);
              cap_d   = arb_id;
              gnt_d   = NREQ'(1) << arb_win;
            end
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      cap_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      id_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      id_q    <= id_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign ack_o  = ack_q;
  assign id_o   = id_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_latency_arbiter.sv
// Directed self-checking bench for latency_arbiter (NREQ=4, LATENCY=3).
// Observed outputs are packed as {gnt, ack, id, busy} and compared against
// hand-computed values 1 time unit after each rising edge.
module tb_latency_arbiter;

  logic        clk_i;
  logic        rst_ni;
  logic        ce_i;
  logic [3:0]  req_i;
  logic [15:0] id_i;
  logic [3:0]  gnt_o;
  logic [3:0]  ack_o;
  logic [3:0]  id_o;
  logic        busy_o;

  int errors;
  int checks;

  logic [12:0] obs;
  logic [12:0] exp_v;

  latency_arbiter #(.NREQ(4), .LATENCY(3)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .ce_i   (ce_i),
    .req_i  (req_i),
    .id_i   (id_i),
    .gnt_o  (gnt_o),
    .ack_o  (ack_o),
    .id_o   (id_o),
    .busy_o (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  assign obs = {gnt_o, ack_o, id_o, busy_o};

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    ce_i   = 1'b1;
    req_i  = '0;
    id_i   = '0;
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    ce_i   = 1'b1;
    req_i  = 4'b1111;
    id_i   = 16'hFFFF;
    #1;
    checks++;
    if (obs !== 13'b0) begin
      errors++;
      $display("FAIL reset_async: got %b expected %b", obs, 13'b0);
    end
    tick();
    checks++;
    if (obs !== 13'b0) begin
      errors++;
      $display("FAIL reset_hold: got %b expected %b", obs, 13'b0);
    end
    req_i  = '0;
    rst_ni = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req_i = 4'b0001;
    id_i  = 16'h000A;
    tick(); // E0
    exp_v = {4'b0001, 4'b0000, 4'h0, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL single_grant: got %b expected %b", obs, exp_v);
    end
    id_i = 16'h0005; // ignored after grant
    tick(); tick(); // E1, E2
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL single_wait: got %b expected %b", obs, exp_v);
    end
    tick(); // E3
    exp_v = {4'b0001, 4'b0001, 4'hA, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL single_ack: got %b expected %b", obs, exp_v);
    end
    tick(); // E4 ack holds
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL single_ack_hold: got %b expected %b", obs, exp_v);
    end
    req_i = 4'b0000;
    tick(); // E5
    checks++;
    if (obs !== 13'b0) begin
      errors++;
      $display("FAIL single_release: got %b expected %b", obs, 13'b0);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] oh;
    logic [3:0] ids [4];
    ids[0] = 4'hA; ids[1] = 4'hB; ids[2] = 4'hC; ids[3] = 4'hD;
    do_reset();
    req_i = 4'b1111;
    id_i  = 16'hDCBA;
    tick(); // first grant
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      exp_v = {oh, 4'b0000, 4'h0, 1'b1};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b expected %b", k, obs, exp_v);
      end
      tick(); tick(); tick();
      exp_v = {oh, oh, ids[k % 4], 1'b1};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rr_ack%0d: got %b expected %b", k, obs, exp_v);
      end
      req_i = 4'b1111 & ~oh;
      tick(); // release edge
      req_i = 4'b1111;
`ifndef LATENCY_ARB_B2B_EN
      checks++;
      if (obs !== 13'b0) begin
        errors++;
        $display("FAIL rr_dead%0d: got %b expected %b", k, obs, 13'b0);
      end
      tick();
`endif
    end
    req_i = '0;
  endtask

  task automatic test_abort();
    do_reset();
    req_i = 4'b0011;
    id_i  = 16'h00BA;
    tick(); // E0
    exp_v = {4'b0001, 4'b0000, 4'h0, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL abort_grant: got %b expected %b", obs, exp_v);
    end
    tick(); // E1
    req_i = 4'b0010;
    tick(); // E2 abort
    checks++;
    if (obs !== 13'b0) begin
      errors++;
      $display("FAIL abort_clear: got %b expected %b", obs, 13'b0);
    end
    tick(); // E3
    exp_v = {4'b0010, 4'b0000, 4'h0, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL abort_next_grant: got %b expected %b", obs, exp_v);
    end
    tick(); tick();
    checks++;
    if (ack_o !== 4'b0000) begin
      errors++;
      $display("FAIL abort_no_ack: got %b expected %b", ack_o, 4'b0000);
    end
    tick(); // E6
    exp_v = {4'b0010, 4'b0010, 4'hB, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL abort_req1_ack: got %b expected %b", obs, exp_v);
    end
    req_i = '0;
    tick();
  endtask

  task automatic test_ce();
    do_reset();
    req_i = 4'b0001;
    id_i  = 16'h0003;
    tick(); // E0
    tick(); // E1
    ce_i = 1'b0;
    exp_v = {4'b0001, 4'b0000, 4'h0, 1'b1};
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL ce_hold%0d: got %b expected %b", c, obs, exp_v);
      end
    end
    ce_i = 1'b1;
    tick(); // effective E2
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL ce_no_early_ack: got %b expected %b", obs, exp_v);
    end
    tick(); // effective E3
    exp_v = {4'b0001, 4'b0001, 4'h3, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL ce_ack: got %b expected %b", obs, exp_v);
    end
    req_i = '0;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    req_i = 4'b0100;
    id_i  = 16'h0700;
    tick(); tick(); tick(); tick();
    exp_v = {4'b0100, 4'b0100, 4'h7, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL areset_pre_ack: got %b expected %b", obs, exp_v);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (obs !== 13'b0) begin
      errors++;
      $display("FAIL areset_clear: got %b expected %b", obs, 13'b0);
    end
    #1;
    req_i  = 4'b1111;
    rst_ni = 1'b1;
    tick();
    exp_v = {4'b0001, 4'b0000, 4'h0, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL areset_first_grant: got %b expected %b", obs, exp_v);
    end
    req_i = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_i = 4'b0011;
    id_i  = 16'h0021;
    tick(); tick(); tick(); tick();
    exp_v = {4'b0001, 4'b0001, 4'h1, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL b2b_ack0: got %b expected %b", obs, exp_v);
    end
    req_i = 4'b0010;
    tick(); // Er
`ifdef LATENCY_ARB_B2B_EN
    exp_v = {4'b0010, 4'b0000, 4'h0, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL b2b_same_edge: got %b expected %b", obs, exp_v);
    end
`else
    checks++;
    if (obs !== 13'b0) begin
      errors++;
      $display("FAIL b2b_dead: got %b expected %b", obs, 13'b0);
    end
    tick(); // Er+1
    exp_v = {4'b0010, 4'b0000, 4'h0, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL b2b_next_grant: got %b expected %b", obs, exp_v);
    end
`endif
    tick(); tick(); tick();
    exp_v = {4'b0010, 4'b0010, 4'h2, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL b2b_ack1: got %b expected %b", obs, exp_v);
    end
    req_i = '0;
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_ni = 1'b0;
    ce_i   = 1'b1;
    req_i  = '0;
    id_i   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_abort();
    test_ce();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/latency_arbiter.md
# latency_arbiter

Round-robin arbiter and sequencer for a shared fixed-latency NoC resource. It grants the resource to one of NREQ requesters and counts the resource latency. It then returns a level ack and the requester's 4-bit transaction id. The ack drops as soon as the owning request drops. The block sits between the requesting NoC ports and a shared slave (ROM, register bank, fixed-latency memory) and replaces per-port ready generators with one shared sequencer.

## Interface
- NREQ, 4, number of requesters (2..8).
- LATENCY, 3, ce-qualified clocks from grant to ack (1..15).
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- ce_i  in  1  clock enable; when low, all state and outputs hold.
- req_i  in  NREQ  request per requester; held high until ack, may drop at any time (abort).
- id_i  in  4*NREQ  transaction id per requester; requester n uses bits [4n+3:4n].
- gnt_o  out  NREQ  one-hot grant; selects the resource mux.
- ack_o  out  NREQ  one-hot ack to the granted requester.
- id_o  out  4  id captured at grant; driven only while an ack is high, else 4'h0.
- busy_o  out  1  high in WAIT or ACK.

## Operation
- Reset values: state IDLE, gnt_o 0, ack_o 0, id_o 0, busy_o 0, rr pointer 0, counter 0.
- All transitions require ce_i=1.
- IDLE:
  - If any req_i is high, pick the first high request searching upward from rr pointer, wrapping modulo NREQ.
  - Set gnt_o[w], capture id_i[w], load counter LATENCY-1, set rr pointer to (w+1) mod NREQ, go to WAIT.
- WAIT:
  - If req_i[w] is low: abort. Clear gnt_o and go to IDLE; no ack is issued and the rr pointer is not restored.
  - Else if counter is 0: set ack_o[w] and id_o to the captured id, go to ACK.
  - Else decrement the counter.
- ACK:
  - ack_o[w] holds while req_i[w] is high.
  - When req_i[w] is sampled low: ack_o, id_o and gnt_o clear on that edge; go to IDLE.
- Only req_i[w] affects the owner. Other requests wait and never preempt.
- Changes to id_i after grant are ignored.
- Counter is 4 bits and never underflows; LATENCY=1 goes from WAIT to ACK on the first WAIT edge.

## Timing
- Request sampled high at edge E0: gnt_o is high after E0, and ack_o/id_o are high after edge E0+LATENCY.
- Release at edge Er without B2B: the next grant is after edge Er+1, giving a one-cycle dead slot on the resource.
- Abort at edge Ea: gnt_o is low after Ea; the next arbitration is at Ea+1.
- An ack never appears in the cycle after its request drops; the combinational path is only from register to output.
- A deasserted ce_i stretches all latencies cycle-for-cycle.
- Reset asserted mid-transaction clears all outputs immediately and asynchronously; no ack is issued afterward.

## Configuration
- LATENCY_ARB_B2B_EN defined:
  - On the ACK release edge, arbitrate among req_i with the released index excluded, starting from the rr pointer.
  - If a winner exists, grant it on the same edge and go directly to WAIT; there is no dead cycle.
- Not defined: release always passes through IDLE, giving one dead cycle between owners.

## Test plan
- Single requester: LATENCY=3, req_i=4'b0001 and id_i[3:0]=4'hA at edge 0 -> gnt_o=0001 after edge 0; ack_o=0001 and id_o=A after edge 3; drop req at edge 5 -> all outputs 0 after edge 5.
- Round-robin: req_i=4'b1111 held, each released one cycle after ack -> grant order 0,1,2,3,0.
- Abort: req0 drops at edge 2 (mid-WAIT) -> gnt_o=0 after edge 2, no ack ever; req1 pending -> granted after edge 3.
- Clock enable: ce_i low for 2 cycles during WAIT -> ack delayed exactly 2 cycles, outputs stable while ce_i is low.
- Async reset: rst_ni pulsed low while in ACK -> ack_o, gnt_o, id_o and busy_o are 0 before the next edge; the first grant after reset goes to requester 0.
- B2B: with LATENCY_ARB_B2B_EN, req0 and req1 pending, req0 released at edge Er -> gnt_o=0010 after Er. Without the macro -> gnt_o=0000 after Er and 0010 after Er+1.
